mem_arbiter: RTL and testbench

Arbitrates one shared single-port synchronous SRAM between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage ARM pipeline. Sequences each multi-cycle SRAM access with an access FSM and a wait counter. Generates the freeze signals that stall the pipeline while an access is outstanding. Sits beside IF_Stage and MEM_Stage; its freeze outputs drive the IF_Stage/IF_Reg freeze inputs and the pipeline-wide stall.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared single-port SRAM arbiter for the IF and MEM stages; data has priority, freezes stall the pipe.
// Optional one-entry fetch buffer enabled with `define ARB_FETCH_BUFFER_EN.
module mem_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int SRAM_WAIT  = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [WORD_WIDTH-1:0] if_addr,
    output logic [WORD_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_rd_en,
    input  logic                  d_wr_en,
    input  logic [WORD_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [WORD_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0] sram_wdata,
    input  logic [WORD_WIDTH-1:0] sram_rdata,
    output logic                  freeze_if,
    output logic                  freeze_pipe
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  owner;
    logic                  we_q;
    logic [WORD_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;

    logic                  d_req;
    logic                  fetch_hit;
    logic [WORD_WIDTH-1:0] hit_data;

    assign d_req = d_rd_en | d_wr_en;

`ifdef ARB_FETCH_BUFFER_EN
    logic                  buf_valid;
    logic [WORD_WIDTH-1:0] buf_tag;
    logic [WORD_WIDTH-1:0] buf_data;

    assign fetch_hit = buf_valid && (if_addr == buf_tag);
    assign hit_data  = buf_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (state == ACCESS && cnt == '0 && owner == OWN_IF) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q;
            buf_data  <= sram_rdata;
        end else if (state == DONE && owner == OWN_D && we_q && addr_q == buf_tag) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign fetch_hit = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            // NOTE: ready defaults low every cycle so it can only ever be a one-cycle pulse.
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        owner   <= OWN_D;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        we_q    <= d_wr_en;
                        cnt     <= CNT_WIDTH'(SRAM_WAIT - 1);
                        state   <= ACCESS;
                    end else if (if_req && !if_ready) begin
                        // if_ready gating stops a held request from re-issuing in its own ready cycle.
                        if (fetch_hit) begin
                            if_ready <= 1'b1;
                            if_rdata <= hit_data;
                        end else begin
                            owner   <= OWN_IF;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                            cnt     <= CNT_WIDTH'(SRAM_WAIT - 1);
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        if (owner == OWN_D) begin
                            if (!we_q) d_rdata <= sram_rdata;
                            d_ready <= d_req;
                        end else begin
                            if_rdata <= sram_rdata;
                            if_ready <= if_req;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign sram_cs    = (state == ACCESS);
    assign sram_we    = sram_cs & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign freeze_pipe = d_req & ~d_ready;
    assign freeze_if   = (if_req & ~if_ready) | freeze_pipe | (sram_cs & (owner == OWN_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: SRAM model, per-cycle signal masks and a read-data scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd_en = 1'b0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        sram_cs;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        freeze_if;
    logic        freeze_pipe;

    mem_arbiter #(.WORD_WIDTH(32), .SRAM_WAIT(3), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .freeze_if(freeze_if), .freeze_pipe(freeze_pipe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM content: written by the DUT; shadow holds what the bench expects it to contain.
    logic [31:0] mem    [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hE3A0_1005;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_word(a);
    endfunction

    always @(negedge clk) sram_rdata = rd_word(sram_addr);
    always @(posedge clk) if (sram_cs && sram_we) mem[sram_addr] = sram_wdata;

    // Scoreboard: expected rdata pushed at issue, popped on each ready pulse.
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] exp_last_d = '0;

    always @(negedge clk) begin
        if (if_ready) begin
            if (if_q.size() == 0) check("if_ready_spurious", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_ready) begin
            if (d_q.size() == 0) check("d_ready_spurious", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    logic [31:0] cs_m, we_m, fzi_m, fzp_m, ifr_m, dr_m;
    logic [31:0] first_addr, last_addr, last_wd;

    // Runs ncyc cycles from cycle 0, recording per-cycle masks; requests drop after their ready.
    task automatic run(input int ncyc, input int drop_if_at);
        logic rdy_if, rdy_d;
        cs_m = '0; we_m = '0; fzi_m = '0; fzp_m = '0; ifr_m = '0; dr_m = '0;
        first_addr = '0; last_addr = '0; last_wd = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (sram_cs) begin
                if (cs_m == '0) first_addr = sram_addr;
                last_addr = sram_addr;
                if (sram_we) last_wd = sram_wdata;
            end
            cs_m[c]  = sram_cs;
            we_m[c]  = sram_we;
            fzi_m[c] = freeze_if;
            fzp_m[c] = freeze_pipe;
            ifr_m[c] = if_ready;
            dr_m[c]  = d_ready;
            rdy_if = if_ready;
            rdy_d  = d_ready;
            @(posedge clk); #1;
            if (rdy_if || c + 1 == drop_if_at) if_req = 1'b0;
            if (rdy_d) begin
                d_rd_en = 1'b0;
                d_wr_en = 1'b0;
            end
        end
    endtask

    task automatic start_fetch(input logic [31:0] a);
        if_q.push_back(exp_word(a));
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic start_load(input logic [31:0] a);
        exp_last_d = exp_word(a);
        d_q.push_back(exp_last_d);
        d_addr  = a;
        d_rd_en = 1'b1;
    endtask

    task automatic start_store(input logic [31:0] a, input logic [31:0] wd, input logic both);
        d_q.push_back(exp_last_d);
        shadow[a] = wd;
        d_addr  = a;
        d_wdata = wd;
        d_wr_en = 1'b1;
        d_rd_en = both;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sram_cs", 32'(sram_cs), 32'd0);
        check("rst_sram_we", 32'(sram_we), 32'd0);
        check("rst_sram_addr", sram_addr, 32'd0);
        check("rst_sram_wdata", sram_wdata, 32'd0);
        check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_freeze", {30'd0, freeze_if, freeze_pipe}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        start_fetch(32'h10);
        run(6, -1);
        check("fetch_cs", cs_m, 32'hE);
        check("fetch_addr_first", first_addr, 32'h10);
        check("fetch_addr_last", last_addr, 32'h10);
        check("fetch_ready", ifr_m, 32'h10);
        check("fetch_freeze_if", fzi_m, 32'hF);
        check("fetch_freeze_pipe", fzp_m, 32'h0);

        start_fetch(32'h10);
        run(6, -1);
`ifdef ARB_FETCH_BUFFER_EN
        check("hit_cs", cs_m, 32'h0);
        check("hit_ready", ifr_m, 32'h2);
        check("hit_freeze_if", fzi_m, 32'h1);
`else
        check("refetch_cs", cs_m, 32'hE);
        check("refetch_ready", ifr_m, 32'h10);
`endif

        start_store(32'h200, 32'hDEAD_BEEF, 1'b0);
        run(6, -1);
        check("store_cs", cs_m, 32'hE);
        check("store_we", we_m, 32'hE);
        check("store_addr", first_addr, 32'h200);
        check("store_wdata", last_wd, 32'hDEAD_BEEF);
        check("store_ready", dr_m, 32'h10);
        check("store_freeze_pipe", fzp_m, 32'hF);
        check("store_freeze_if", fzi_m, 32'hF);

        start_store(32'h10, 32'h1234_5678, 1'b0);
        run(6, -1);
        check("store10_we", we_m, 32'hE);

        start_fetch(32'h10);
        run(6, -1);
        check("fetch_after_store_cs", cs_m, 32'hE);
        check("fetch_after_store_ready", ifr_m, 32'h10);

        start_load(32'h200);
        run(6, -1);
        check("load_we", we_m, 32'h0);
        check("load_ready", dr_m, 32'h10);

        start_load(32'h100);
        start_fetch(32'h20);
        run(12, -1);
        check("coll_cs", cs_m, 32'h1CE);
        check("coll_first_addr", first_addr, 32'h100);
        check("coll_last_addr", last_addr, 32'h20);
        check("coll_d_ready", dr_m, 32'h10);
        check("coll_if_ready", ifr_m, 32'h200);
        check("coll_freeze_pipe", fzp_m, 32'hF);
        check("coll_freeze_if", fzi_m, 32'h1FF);

        if_q.push_back(32'h0);
        void'(if_q.pop_back());
        if_addr = 32'h30;
        if_req  = 1'b1;
        run(6, 2);
        check("drop_cs", cs_m, 32'hE);
        check("drop_ready", ifr_m, 32'h0);
        check("drop_freeze_if", fzi_m, 32'h3);
        check("drop_rdata", if_rdata, exp_word(32'h30));

        start_store(32'h300, 32'hCAFE_F00D, 1'b1);
        run(6, -1);
        check("both_we", we_m, 32'hE);
        check("both_ready", dr_m, 32'h10);
        check("both_wdata", last_wd, 32'hCAFE_F00D);

        if_addr = 32'h40;
        if_req  = 1'b1;
        run(2, -1);
        check("pre_rst_cs", 32'(sram_cs), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_cs", 32'(sram_cs), 32'd0);
        check("rst_mid_we", 32'(sram_we), 32'd0);
        check("rst_mid_ready", 32'(if_ready), 32'd0);
        check("rst_mid_d_rdata", d_rdata, 32'd0);
        exp_last_d = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        if_q.push_back(exp_word(32'h40));
        run(6, -1);
        check("post_rst_cs", cs_m, 32'hE);
        check("post_rst_ready", ifr_m, 32'h10);

        start_load(32'h10);
        run(6, -1);
        check("readback_ready", dr_m, 32'h10);

        repeat (3) @(posedge clk);
        check("if_q_empty", 32'(if_q.size()), 32'd0);
        check("d_q_empty", 32'(d_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
